frame_ram_writer: RTL and testbench
===================================

// Module: frame_ram_writer
// PURPOSE
//  Write side of the double-buffered frame RAM that the column framebuffer reads.
//  Takes a raster-order RGB pixel stream from the video input and writes each pixel
//  transposed into column-major order: addr = x*IMG_H + y, so the reader's strided
//  column fetch sees contiguous data. Owns the two-bank ping-pong and the bank swap.
//  The swap is handshaked with the reader's end-of-read pulse.
// PARAMETERS
//  IMG_W  80  pixels per input row (columns)
//  IMG_H  48  rows per frame
//  FRAME_WORDS  IMG_W*IMG_H (localparam)  words per bank; bank b base = b*FRAME_WORDS
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous active-high reset
//  rgb_valid      in   1   pixel strobe, one pixel per cycle when high
//  rgb_sof        in   1   qualifies rgb_valid: this pixel is (0,0) of a new frame
//  rgb_data       in   24  pixel {R,G,B}
//  ram_wr_en      out  1   RAM write strobe
//  ram_wr_addr    out  32  RAM write word address (bank base + x*IMG_H + y)
//  ram_wr_data    out  24  RAM write data
//  rd_eof         in   1   1-cycle pulse from reader: read bank fully consumed (EOR)
//  rd_bank        out  1   bank the reader must use; reader adds rd_bank*FRAME_WORDS
//  frame_pending  out  1   complete frame waiting in write bank for swap
//  frames_dropped out  16  saturating count of pending frames overwritten
//  err_short      out  1   sticky: frame aborted by rgb_sof before last pixel
// BEHAVIOUR
//  Reset (sync, rst=1): ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, rd_bank=0,
//   write bank wb=1, frame_pending=0, frames_dropped=0, err_short=0, state=IDLE.
//  Reset mid-frame aborts the frame; no partial write follows.
//  FSM
//  - IDLE: rgb_valid & ~rgb_sof ignored (no write).
//  - IDLE: rgb_valid & rgb_sof -> write pixel (0,0); x=1 (or y=1 if IMG_W=1); go WRITE.
//  - WRITE: each rgb_valid writes (x,y).
//  - x counts 0..IMG_W-1, then wraps to 0 and y increments.
//  - Last pixel (x=IMG_W-1, y=IMG_H-1) written -> frame_pending<=1, IDLE.
//  - WRITE & rgb_valid & rgb_sof: err_short<=1, drop partial frame, restart at (0,0) same cycle.
//  Address: column offset col_base steps by IMG_H per x, so ram_wr_addr = wb_base+col_base+y.
//   No multiplier.
//  Latency: pixel accepted at edge N appears on ram_wr_* in cycle N+1, one cycle wide.
//  Swap (one cycle):
//  - rd_eof & frame_pending: rd_bank<=wb, wb<=~wb, frame_pending<=0.
//  - rd_eof & ~frame_pending: nothing; reader re-reads same bank.
//  Simultaneous events:
//  - Last pixel and rd_eof in the same cycle: the completing frame is swapped in that
//    cycle, frame_pending stays 0.
//  - rgb_sof accepted while frame_pending=1 and no rd_eof: pending frame overwritten;
//    frame_pending<=0, frames_dropped+=1 (saturates at 16'hFFFF).
//  - rgb_sof and rd_eof in the same cycle with frame_pending=1: swap first; the new frame
//    goes to the new wb (old read bank); no drop.
//  Invariant: wb != rd_bank always; the writer never writes the bank being read.
// STRUCTURE
//  Shared package spirose_pkg:
//  - typedef rgb_t (logic[23:0]); RAM_ADDR_W=32
//  - typedef enum {IDLE,WRITE} fw_state_t
//  Sub-module raster_to_col_addr:
//  - holds x, y, col_base counters with clear and step inputs
//  - outputs offset and last_pixel
//  Top holds FSM, bank/pending logic, output registers.
// TESTING  (IMG_W=4, IMG_H=3, FRAME_WORDS=12)
//  1 Reset, one full frame p0..p11 with sof on p0:
//    - writes at addrs 12,15,18,21,13,16,19,22,14,17,20,23 (wb=1), one per cycle, 1 cycle late
//    - then frame_pending=1
//  2 After 1, pulse rd_eof -> next cycle rd_bank=1, frame_pending=0.
//    Next frame writes addrs 0,3,6,9,1,...
//  3 IDLE, 5 valid pixels without sof -> ram_wr_en stays 0, no state change.
//  4 sof at pixel 0, 6 pixels, sof again -> err_short=1, 7th write goes to offset 0, frame then completes normally.
//  5 Two complete frames, no rd_eof -> frames_dropped=1, second frame pending, rd_bank unchanged.
//  6 Last pixel and rd_eof in same cycle -> rd_bank toggles next cycle, frame_pending stays 0.
//    Also rst asserted mid-frame -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/spirose_pkg.sv
// rtl/spirose_pkg.sv - shared types and helpers for the frame RAM writer
package spirose_pkg;

    localparam int RAM_ADDR_W = 32;

    typedef logic [23:0] rgb_t;

    typedef enum logic {
        IDLE,
        WRITE
    } fw_state_t;

    function automatic logic [RAM_ADDR_W-1:0] bank_base(input logic bank, input int frame_words);
        return bank ? RAM_ADDR_W'(frame_words) : '0;
    endfunction

endpackage

// File: rtl/frame_ram_writer_if.sv
// rtl/frame_ram_writer_if.sv - pixel stream, RAM write port and reader handshake bundle
interface frame_ram_writer_if;
    import spirose_pkg::*;

    logic                  rgb_valid;
    logic                  rgb_sof;
    rgb_t                  rgb_data;
    logic                  ram_wr_en;
    logic [RAM_ADDR_W-1:0] ram_wr_addr;
    rgb_t                  ram_wr_data;
    logic                  rd_eof;
    logic                  rd_bank;
    logic                  frame_pending;
    logic [15:0]           frames_dropped;
    logic                  err_short;

    modport master (
        output rgb_valid, rgb_sof, rgb_data, rd_eof,
        input  ram_wr_en, ram_wr_addr, ram_wr_data, rd_bank,
        input  frame_pending, frames_dropped, err_short
    );

    modport slave (
        input  rgb_valid, rgb_sof, rgb_data, rd_eof,
        output ram_wr_en, ram_wr_addr, ram_wr_data, rd_bank,
        output frame_pending, frames_dropped, err_short
    );
endinterface

// File: rtl/frame_ram_writer_raster_to_col_addr.sv
// rtl/frame_ram_writer_raster_to_col_addr.sv - raster position counters yielding column-major offset
module raster_to_col_addr
    import spirose_pkg::*;
#(
    parameter int IMG_W = 80,
    parameter int IMG_H = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  step,
    output logic [RAM_ADDR_W-1:0] offset,
    output logic                  last_pixel
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [XW-1:0]         x, src_x, nxt_x;
    logic [YW-1:0]         y, src_y, nxt_y;
    logic [RAM_ADDR_W-1:0] col_base, src_col, nxt_col;

    // clear and step together means "origin consumed": land on the pixel after (0,0)
    always_comb begin
        src_x   = clear ? '0 : x;
        src_y   = clear ? '0 : y;
        src_col = clear ? '0 : col_base;
        nxt_x   = src_x;
        nxt_y   = src_y;
        nxt_col = src_col;
        if (step) begin
            if (src_x == XW'(IMG_W - 1)) begin
                nxt_x   = '0;
                nxt_y   = src_y + 1'b1;
                nxt_col = '0;
            end else begin
                nxt_x   = src_x + 1'b1;
                nxt_col = src_col + RAM_ADDR_W'(IMG_H);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            col_base <= '0;
        end else begin
            x        <= nxt_x;
            y        <= nxt_y;
            col_base <= nxt_col;
        end
    end

    assign offset     = col_base + RAM_ADDR_W'(y);
    assign last_pixel = (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1));

endmodule

// File: rtl/frame_ram_writer.sv
// rtl/frame_ram_writer.sv - transposing ping-pong frame RAM writer with reader-handshaked bank swap
module frame_ram_writer
    import spirose_pkg::*;
#(
    parameter int IMG_W = 80,
    parameter int IMG_H = 48
) (
    input  logic                clk,
    input  logic                rst,
    frame_ram_writer_if.slave   bus
);
    localparam int   FRAME_WORDS = IMG_W * IMG_H;
    localparam logic ORIGIN_LAST = (IMG_W == 1) && (IMG_H == 1);

    fw_state_t             state;
    logic                  wb;
    logic                  rd_bank_q;
    logic                  pending_q;
    logic [15:0]           dropped_q;
    logic                  err_q;
    logic                  wr_en_q;
    logic [RAM_ADDR_W-1:0] wr_addr_q;
    rgb_t                  wr_data_q;

    logic                  is_sof, accept, pix_last, frame_done;
    logic                  swap_pending, swap_done, drop;
    logic                  ctr_clear, ctr_step, pix_bank;
    logic [RAM_ADDR_W-1:0] offset, wr_off;
    logic                  last_pixel;

    raster_to_col_addr #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_addr (
        .clk        (clk),
        .rst        (rst),
        .clear      (ctr_clear),
        .step       (ctr_step),
        .offset     (offset),
        .last_pixel (last_pixel)
    );

    always_comb begin
        is_sof     = bus.rgb_valid & bus.rgb_sof;
        accept     = is_sof | (bus.rgb_valid & (state == WRITE));
        pix_last   = is_sof ? ORIGIN_LAST : last_pixel;
        wr_off     = is_sof ? '0 : offset;
        frame_done = accept & pix_last;
        // a waiting frame swaps first; otherwise a frame finishing this cycle swaps itself
        swap_pending = bus.rd_eof & pending_q;
        swap_done    = bus.rd_eof & ~pending_q & frame_done;
        drop         = is_sof & pending_q & ~bus.rd_eof;
        // after a pending swap the new frame lands in the bank the reader just released
        pix_bank     = swap_pending ? ~wb : wb;
        ctr_clear    = is_sof | frame_done;
        ctr_step     = accept & ~pix_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wb        <= 1'b1;
            rd_bank_q <= 1'b0;
            pending_q <= 1'b0;
            dropped_q <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= accept;
            if (accept) begin
                wr_addr_q <= bank_base(pix_bank, FRAME_WORDS) + wr_off;
                wr_data_q <= bus.rgb_data;
                state     <= pix_last ? IDLE : WRITE;
            end
            if (is_sof && state == WRITE)
                err_q <= 1'b1;
            if (swap_pending || swap_done) begin
                rd_bank_q <= wb;
                wb        <= ~wb;
            end
            if (drop && dropped_q != 16'hFFFF)
                dropped_q <= dropped_q + 16'd1;
            if (frame_done && !swap_done)
                pending_q <= 1'b1;
            else if (swap_pending || drop)
                pending_q <= 1'b0;
        end
    end

    assign bus.ram_wr_en      = wr_en_q;
    assign bus.ram_wr_addr    = wr_addr_q;
    assign bus.ram_wr_data    = wr_data_q;
    assign bus.rd_bank        = rd_bank_q;
    assign bus.frame_pending  = pending_q;
    assign bus.frames_dropped = dropped_q;
    assign bus.err_short      = err_q;

endmodule

// File: tb/tb_frame_ram_writer.sv
// tb/tb_frame_ram_writer.sv - directed self-checking bench for frame_ram_writer (4x3 frames)
module tb_frame_ram_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    frame_ram_writer_if bus();

    frame_ram_writer #(.IMG_W(4), .IMG_H(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // column-major address of raster index i in a 4x3 frame: x*3 + y
    function automatic int col_addr(input int base, input int i);
        return base + (i % 4) * 3 + (i / 4);
    endfunction

    task automatic pix(input logic v, input logic s, input logic e, input logic [23:0] d);
        @(negedge clk);
        bus.rgb_valid = v;
        bus.rgb_sof   = s;
        bus.rd_eof    = e;
        bus.rgb_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pix(1'b1, 1'b1, 1'b0, 24'h123456);
        pix(1'b0, 1'b0, 1'b0, 24'h0);
        rst = 1'b0;
        n_cmp += 7;
        if (bus.ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", bus.ram_wr_en); end
        if (bus.ram_wr_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", bus.ram_wr_addr); end
        if (bus.ram_wr_data !== 24'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.ram_wr_data); end
        if (bus.rd_bank !== 1'b0) begin n_fail++; $display("FAIL reset_rd_bank got %b want 0", bus.rd_bank); end
        if (bus.frame_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", bus.frame_pending); end
        if (bus.frames_dropped !== 16'd0) begin n_fail++; $display("FAIL reset_dropped got %0d want 0", bus.frames_dropped); end
        if (bus.err_short !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err_short); end
    endtask

    task automatic test_full_frame;
        int exp_addr[12] = '{12, 15, 18, 21, 13, 16, 19, 22, 14, 17, 20, 23};
        for (int i = 0; i < 12; i++) begin
            pix(1'b1, i == 0, 1'b0, 24'hA00000 + 24'(i));
            n_cmp++;
            if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_addr !== 32'(exp_addr[i]) || bus.ram_wr_data !== 24'hA00000 + 24'(i)) begin
                n_fail++;
                $display("FAIL frame1_write[%0d] got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h",
                         i, bus.ram_wr_en, bus.ram_wr_addr, bus.ram_wr_data, exp_addr[i], 24'hA00000 + 24'(i));
            end
        end
        pix(1'b0, 1'b0, 1'b0, 24'h0);
        n_cmp += 2;
        if (bus.ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL frame1_en_after got %b want 0", bus.ram_wr_en); end
        if (bus.frame_pending !== 1'b1) begin n_fail++; $display("FAIL frame1_pending got %b want 1", bus.frame_pending); end
    endtask

    task automatic test_swap;
        int exp_addr[12] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
        pix(1'b0, 1'b0, 1'b1, 24'h0);
        n_cmp += 2;
        if (bus.rd_bank !== 1'b1) begin n_fail++; $display("FAIL swap_rd_bank got %b want 1", bus.rd_bank); end
        if (bus.frame_pending !== 1'b0) begin n_fail++; $display("FAIL swap_pending got %b want 0", bus.frame_pending); end
        for (int i = 0; i < 12; i++) begin
            pix(1'b1, i == 0, 1'b0, 24'hB00000 + 24'(i));
            n_cmp++;
            if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_addr !== 32'(exp_addr[i])) begin
                n_fail++;
                $display("FAIL frame2_write[%0d] got en=%b addr=%0d want en=1 addr=%0d", i, bus.ram_wr_en, bus.ram_wr_addr, exp_addr[i]);
            end
        end
        pix(1'b0, 1'b0, 1'b0, 24'h0);
        n_cmp++;
        if (bus.frame_pending !== 1'b1) begin n_fail++; $display("FAIL frame2_pending got %b want 1", bus.frame_pending); end
    endtask

    task automatic test_idle_no_sof;
        for (int i = 0; i < 5; i++) begin
            pix(1'b1, 1'b0, 1'b0, 24'hC00000 + 24'(i));
            n_cmp++;
            if (bus.ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL idle_en[%0d] got %b want 0", i, bus.ram_wr_en); end
        end
        n_cmp += 3;
        if (bus.frame_pending !== 1'b1) begin n_fail++; $display("FAIL idle_pending got %b want 1", bus.frame_pending); end
        if (bus.frames_dropped !== 16'd0) begin n_fail++; $display("FAIL idle_dropped got %0d want 0", bus.frames_dropped); end
        if (bus.rd_bank !== 1'b1) begin n_fail++; $display("FAIL idle_rd_bank got %b want 1", bus.rd_bank); end
    endtask

    task automatic test_short_frame;
        pix(1'b0, 1'b0, 1'b1, 24'h0);
        n_cmp++;
        if (bus.rd_bank !== 1'b0) begin n_fail++; $display("FAIL short_swap_rd_bank got %b want 0", bus.rd_bank); end
        for (int i = 0; i < 6; i++) begin
            pix(1'b1, i == 0, 1'b0, 24'hD00000 + 24'(i));
            n_cmp++;
            if (bus.ram_wr_addr !== 32'(col_addr(12, i))) begin
                n_fail++; $display("FAIL short_part[%0d] got addr=%0d want %0d", i, bus.ram_wr_addr, col_addr(12, i));
            end
        end
        n_cmp++;
        if (bus.err_short !== 1'b0) begin n_fail++; $display("FAIL short_err_early got %b want 0", bus.err_short); end
        for (int i = 0; i < 12; i++) begin
            pix(1'b1, i == 0, 1'b0, 24'hE00000 + 24'(i));
            n_cmp++;
            if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_addr !== 32'(col_addr(12, i))) begin
                n_fail++; $display("FAIL short_restart[%0d] got en=%b addr=%0d want en=1 addr=%0d", i, bus.ram_wr_en, bus.ram_wr_addr, col_addr(12, i));
            end
        end
        pix(1'b0, 1'b0, 1'b0, 24'h0);
        n_cmp += 3;
        if (bus.err_short !== 1'b1) begin n_fail++; $display("FAIL short_err got %b want 1", bus.err_short); end
        if (bus.frame_pending !== 1'b1) begin n_fail++; $display("FAIL short_pending got %b want 1", bus.frame_pending); end
        if (bus.frames_dropped !== 16'd0) begin n_fail++; $display("FAIL short_dropped got %0d want 0", bus.frames_dropped); end
    endtask

    task automatic test_drop;
        pix(1'b1, 1'b1, 1'b0, 24'hF00000);
        n_cmp += 3;
        if (bus.frames_dropped !== 16'd1) begin n_fail++; $display("FAIL drop_count got %0d want 1", bus.frames_dropped); end
        if (bus.frame_pending !== 1'b0) begin n_fail++; $display("FAIL drop_pending_clr got %b want 0", bus.frame_pending); end
        if (bus.ram_wr_addr !== 32'd12) begin n_fail++; $display("FAIL drop_addr0 got %0d want 12", bus.ram_wr_addr); end
        for (int i = 1; i < 12; i++) pix(1'b1, 1'b0, 1'b0, 24'hF00000 + 24'(i));
        n_cmp++;
        if (bus.ram_wr_addr !== 32'd23) begin n_fail++; $display("FAIL drop_last_addr got %0d want 23", bus.ram_wr_addr); end
        pix(1'b0, 1'b0, 1'b0, 24'h0);
        n_cmp += 3;
        if (bus.frame_pending !== 1'b1) begin n_fail++; $display("FAIL drop_pending got %b want 1", bus.frame_pending); end
        if (bus.rd_bank !== 1'b0) begin n_fail++; $display("FAIL drop_rd_bank got %b want 0", bus.rd_bank); end
        if (bus.frames_dropped !== 16'd1) begin n_fail++; $display("FAIL drop_count_end got %0d want 1", bus.frames_dropped); end
    endtask

    task automatic test_last_eof;
        pix(1'b0, 1'b0, 1'b1, 24'h0);
        for (int i = 0; i < 11; i++) pix(1'b1, i == 0, 1'b0, 24'h110000 + 24'(i));
        n_cmp++;
        if (bus.rd_bank !== 1'b1) begin n_fail++; $display("FAIL lasteof_before got %b want 1", bus.rd_bank); end
        pix(1'b1, 1'b0, 1'b1, 24'h11000B);
        n_cmp += 3;
        if (bus.ram_wr_addr !== 32'd11) begin n_fail++; $display("FAIL lasteof_addr got %0d want 11", bus.ram_wr_addr); end
        if (bus.rd_bank !== 1'b0) begin n_fail++; $display("FAIL lasteof_rd_bank got %b want 0", bus.rd_bank); end
        if (bus.frame_pending !== 1'b0) begin n_fail++; $display("FAIL lasteof_pending got %b want 0", bus.frame_pending); end
    endtask

    task automatic test_sof_eof;
        for (int i = 0; i < 12; i++) pix(1'b1, i == 0, 1'b0, 24'h220000 + 24'(i));
        pix(1'b0, 1'b0, 1'b0, 24'h0);
        n_cmp++;
        if (bus.frame_pending !== 1'b1) begin n_fail++; $display("FAIL sofeof_pending_pre got %b want 1", bus.frame_pending); end
        pix(1'b1, 1'b1, 1'b1, 24'h330000);
        n_cmp += 4;
        if (bus.ram_wr_addr !== 32'd0) begin n_fail++; $display("FAIL sofeof_addr got %0d want 0", bus.ram_wr_addr); end
        if (bus.rd_bank !== 1'b1) begin n_fail++; $display("FAIL sofeof_rd_bank got %b want 1", bus.rd_bank); end
        if (bus.frame_pending !== 1'b0) begin n_fail++; $display("FAIL sofeof_pending got %b want 0", bus.frame_pending); end
        if (bus.frames_dropped !== 16'd1) begin n_fail++; $display("FAIL sofeof_dropped got %0d want 1", bus.frames_dropped); end
    endtask

    task automatic test_reset_mid;
        pix(1'b1, 1'b0, 1'b0, 24'h330001);
        n_cmp++;
        if (bus.ram_wr_addr !== 32'd3) begin n_fail++; $display("FAIL mid_addr got %0d want 3", bus.ram_wr_addr); end
        @(negedge clk);
        rst = 1'b1;
        pix(1'b1, 1'b0, 1'b0, 24'h330002);
        rst = 1'b0;
        n_cmp += 6;
        if (bus.ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_en got %b want 0", bus.ram_wr_en); end
        if (bus.ram_wr_addr !== 32'd0) begin n_fail++; $display("FAIL mid_rst_addr got %0d want 0", bus.ram_wr_addr); end
        if (bus.rd_bank !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rd_bank got %b want 0", bus.rd_bank); end
        if (bus.frames_dropped !== 16'd0) begin n_fail++; $display("FAIL mid_rst_dropped got %0d want 0", bus.frames_dropped); end
        if (bus.err_short !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got %b want 0", bus.err_short); end
        if (bus.frame_pending !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pending got %b want 0", bus.frame_pending); end
        pix(1'b1, 1'b0, 1'b0, 24'h330003);
        n_cmp++;
        if (bus.ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_post_en got %b want 0", bus.ram_wr_en); end
        pix(1'b1, 1'b1, 1'b0, 24'h440000);
        n_cmp++;
        if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_addr !== 32'd12) begin
            n_fail++; $display("FAIL mid_post_sof got en=%b addr=%0d want en=1 addr=12", bus.ram_wr_en, bus.ram_wr_addr);
        end
        pix(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        bus.rgb_valid = 1'b0;
        bus.rgb_sof   = 1'b0;
        bus.rd_eof    = 1'b0;
        bus.rgb_data  = '0;
        test_reset();
        test_full_frame();
        test_swap();
        test_idle_no_sof();
        test_short_frame();
        test_drop();
        test_last_eof();
        test_sof_eof();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
